cnn_layer_scheduler: RTL and testbench

//  Top-level sequencer for the CNN accelerator. Runs six layer engines strictly in order:

---
 rtl/cnn_layer_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_cnn_layer_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_scheduler.sv
// cnn_layer_scheduler: top-level sequencer for the CNN accelerator.
// Runs six layer engines in fixed order (CONV0, CONV1, POOL0, POOL1, FLAT0, FLAT1),
// muxes the shared layer-memory bus to the active engine with one cycle of latency,
// derives the bank select per stage and drives the host busy/ready handshake.
// Optional feature: define STAGE_WATCHDOG_EN to add a per-stage timeout that sets a
// sticky err flag and returns the sequencer to idle.
module cnn_layer_scheduler #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 20,
    parameter int NSTG      = 6,
    parameter int TIMEOUT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ready,
    output logic                   busy,
    output logic [NSTG-1:0]        stg_start,
    input  logic [NSTG-1:0]        stg_done,
    input  logic [NSTG-1:0]        eng_cwr,
    input  logic [NSTG*ADDR_W-1:0] eng_caddr_wr,
    input  logic [NSTG*DATA_W-1:0] eng_cdata_wr,
    input  logic [NSTG-1:0]        eng_crd,
    input  logic [NSTG*ADDR_W-1:0] eng_caddr_rd,
    output logic                   cwr,
    output logic [ADDR_W-1:0]      caddr_wr,
    output logic [DATA_W-1:0]      cdata_wr,
    output logic                   crd,
    output logic [ADDR_W-1:0]      caddr_rd,
    output logic [2:0]             csel,
    output logic [2:0]             stg_idx,
    output logic                   err
);

    localparam logic [2:0] LAST_IDX = 3'(NSTG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [2:0]          idx_r, idx_s;
    logic                busy_r, busy_s;
    logic [NSTG-1:0]     start_r, start_s;
    logic                cwr_r, cwr_s;
    logic                crd_r, crd_s;
    logic [ADDR_W-1:0]   caddr_wr_r, caddr_wr_s;
    logic [DATA_W-1:0]   cdata_wr_r, cdata_wr_s;
    logic [ADDR_W-1:0]   caddr_rd_r, caddr_rd_s;
    logic [2:0]          csel_r, csel_s;
    logic                done_ok_s;

    // Per-engine views of the flattened bus inputs
    logic [ADDR_W-1:0]   awr_a [NSTG];
    logic [DATA_W-1:0]   dwr_a [NSTG];
    logic [ADDR_W-1:0]   ard_a [NSTG];

`ifdef STAGE_WATCHDOG_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] wd_cnt_r, wd_cnt_s;
    logic                 err_r, err_s;
`endif

    for (genvar g = 0; g < NSTG; g++) begin : g_unpack
        assign awr_a[g] = eng_caddr_wr[g*ADDR_W +: ADDR_W];
        assign dwr_a[g] = eng_cdata_wr[g*DATA_W +: DATA_W];
        assign ard_a[g] = eng_caddr_rd[g*ADDR_W +: ADDR_W];
    end

    // Bank written by each stage
    function automatic logic [2:0] wr_bank(input logic [2:0] idx);
        case (idx)
            3'd0:    wr_bank = 3'd1;
            3'd1:    wr_bank = 3'd2;
            3'd2:    wr_bank = 3'd3;
            3'd3:    wr_bank = 3'd4;
            3'd4:    wr_bank = 3'd5;
            3'd5:    wr_bank = 3'd5;
            default: wr_bank = 3'd0;
        endcase
    endfunction

    // Bank read by each stage; the CONV stages read no layer bank and park on 0
    function automatic logic [2:0] rd_bank(input logic [2:0] idx);
        case (idx)
            3'd0:    rd_bank = 3'd0;
            3'd1:    rd_bank = 3'd0;
            3'd2:    rd_bank = 3'd1;
            3'd3:    rd_bank = 3'd2;
            3'd4:    rd_bank = 3'd3;
            3'd5:    rd_bank = 3'd4;
            default: rd_bank = 3'd0;
        endcase
    endfunction

    function automatic logic [NSTG-1:0] onehot(input logic [2:0] idx);
        onehot = {{(NSTG-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Next-state, start pulse and bus-mux decisions for the stage sequencer
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        busy_s     = busy_r;
        start_s    = '0;
        cwr_s      = 1'b0;
        crd_s      = 1'b0;
        caddr_wr_s = caddr_wr_r;
        cdata_wr_s = cdata_wr_r;
        caddr_rd_s = caddr_rd_r;
        csel_s     = csel_r;
        // A done raised while the start pulse is still visible belongs to no stage yet
        done_ok_s  = (start_r == '0) && stg_done[idx_r];
`ifdef STAGE_WATCHDOG_EN
        wd_cnt_s   = wd_cnt_r;
        err_s      = err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (ready) begin
                    busy_s  = 1'b1;
                    idx_s   = 3'd0;
                    start_s = onehot(3'd0);
                    state_s = ST_RUN;
`ifdef STAGE_WATCHDOG_EN
                    err_s    = 1'b0;
                    wd_cnt_s = '0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Write wins when an engine strobes both directions
                cwr_s      = eng_cwr[idx_r];
                crd_s      = eng_crd[idx_r] & ~eng_cwr[idx_r];
                caddr_wr_s = awr_a[idx_r];
                cdata_wr_s = dwr_a[idx_r];
                caddr_rd_s = ard_a[idx_r];
                csel_s     = eng_cwr[idx_r] ? wr_bank(idx_r) : rd_bank(idx_r);
`ifdef STAGE_WATCHDOG_EN
                wd_cnt_s   = wd_cnt_r + 1'b1;
`endif
                if (done_ok_s) begin
                    if (idx_r == LAST_IDX) begin
                        busy_s  = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = ST_GAP;
                    end
                end else begin
`ifdef STAGE_WATCHDOG_EN
                    if (wd_cnt_r == WD_LAST) begin
                        err_s   = 1'b1;
                        busy_s  = 1'b0;
                        cwr_s   = 1'b0;
                        crd_s   = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RUN;
                    end
`else
                    state_s = ST_RUN;
`endif
                end
            end
            ST_GAP: begin
                start_s = onehot(idx_r);
                state_s = ST_RUN;
`ifdef STAGE_WATCHDOG_EN
                wd_cnt_s = '0;
`endif
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update; reset aborts any run immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= 3'd0;
            busy_r     <= 1'b0;
            start_r    <= '0;
            cwr_r      <= 1'b0;
            crd_r      <= 1'b0;
            caddr_wr_r <= '0;
            cdata_wr_r <= '0;
            caddr_rd_r <= '0;
            csel_r     <= 3'd0;
`ifdef STAGE_WATCHDOG_EN
            wd_cnt_r   <= '0;
            err_r      <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            busy_r     <= busy_s;
            start_r    <= start_s;
            cwr_r      <= cwr_s;
            crd_r      <= crd_s;
            caddr_wr_r <= caddr_wr_s;
            cdata_wr_r <= cdata_wr_s;
            caddr_rd_r <= caddr_rd_s;
            csel_r     <= csel_s;
`ifdef STAGE_WATCHDOG_EN
            wd_cnt_r   <= wd_cnt_s;
            err_r      <= err_s;
`endif
        end
    end

    assign busy      = busy_r;
    assign stg_start = start_r;
    assign cwr       = cwr_r;
    assign crd       = crd_r;
    assign caddr_wr  = caddr_wr_r;
    assign cdata_wr  = cdata_wr_r;
    assign caddr_rd  = caddr_rd_r;
    assign csel      = csel_r;
    assign stg_idx   = idx_r;

`ifdef STAGE_WATCHDOG_EN
    assign err = err_r;
`else
    // Without the watchdog nothing can raise err; the term is sized by TIMEOUT_W
    assign err = |{TIMEOUT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// tb_cnn_layer_scheduler: self-checking bench for cnn_layer_scheduler.
// Randomized engine traffic is compared against a stage-level reference built from
// the bank table and the write-wins / one-cycle-latency rules.
// Define STAGE_WATCHDOG_EN to also exercise the watchdog with a 4-bit counter.
module tb_cnn_layer_scheduler;

    localparam int AW = 12;
    localparam int DW = 20;
    localparam int NS = 6;
`ifdef STAGE_WATCHDOG_EN
    localparam int TW = 4;
`else
    localparam int TW = 16;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ready;
    logic              busy;
    logic [NS-1:0]     stg_start;
    logic [NS-1:0]     stg_done;
    logic [NS-1:0]     eng_cwr;
    logic [NS*AW-1:0]  eng_caddr_wr;
    logic [NS*DW-1:0]  eng_cdata_wr;
    logic [NS-1:0]     eng_crd;
    logic [NS*AW-1:0]  eng_caddr_rd;
    logic              cwr;
    logic [AW-1:0]     caddr_wr;
    logic [DW-1:0]     cdata_wr;
    logic              crd;
    logic [AW-1:0]     caddr_rd;
    logic [2:0]        csel;
    logic [2:0]        stg_idx;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference bank table: write bank and read bank per stage
    logic [2:0] wr_tbl [NS] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    logic [2:0] rd_tbl [NS] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    cnn_layer_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .NSTG(NS), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .stg_start(stg_start), .stg_done(stg_done),
        .eng_cwr(eng_cwr), .eng_caddr_wr(eng_caddr_wr), .eng_cdata_wr(eng_cdata_wr),
        .eng_crd(eng_crd), .eng_caddr_rd(eng_caddr_rd),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
        .caddr_rd(caddr_rd), .csel(csel), .stg_idx(stg_idx), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [NS-1:0] stage_mask(input int s);
        return 6'(1) << s;
    endfunction

    task automatic clear_eng();
        eng_cwr = '0; eng_crd = '0;
        eng_caddr_wr = '0; eng_cdata_wr = '0; eng_caddr_rd = '0;
    endtask

    task automatic rand_eng();
        eng_cwr = 6'($urandom);
        eng_crd = 6'($urandom);
        for (int i = 0; i < NS; i++) begin
            eng_caddr_wr[i*AW +: AW] = 12'($urandom);
            eng_cdata_wr[i*DW +: DW] = 20'($urandom);
            eng_caddr_rd[i*AW +: AW] = 12'($urandom);
        end
    endtask

    // Pulse ready from idle; returns at the negedge where stage 0's start is visible
    task automatic start_run();
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
    endtask

    // Called with stage s's start visible; finishes s and returns with s+1's start visible
    task automatic advance(input int s);
        @(negedge clk);
        stg_done = stage_mask(s);
        @(negedge clk);
        stg_done = '0;
        if (s < NS - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, stg_start, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, stg_idx, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b start=%b cwr=%b crd=%b csel=%0d idx=%0d err=%b, required all zero",
                     busy, stg_start, cwr, crd, csel, stg_idx, err);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || stg_start !== '0) begin
            n_fail++;
            $display("FAIL idle_without_ready: got busy=%b start=%b, required 0/000000", busy, stg_start);
        end
    endtask

    task automatic test_full_run();
        int lat;
        logic m_cwr, m_crd;
        logic [AW-1:0] m_awr, m_ard;
        logic [DW-1:0] m_dwr;
        logic [2:0] m_csel;
        m_cwr = 1'b0; m_crd = 1'b0; m_awr = '0; m_ard = '0; m_dwr = '0; m_csel = 3'd0;
        start_run();
        for (int s = 0; s < NS; s++) begin
            n_checks++;
            if (stg_start !== stage_mask(s) || stg_idx !== 3'(s) || busy !== 1'b1 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL stage_start[%0d]: got start=%b idx=%0d busy=%b err=%b, required start=%b idx=%0d busy=1 err=0",
                         s, stg_start, stg_idx, busy, err, stage_mask(s), s);
            end
            n_checks++;
            if (cwr !== 1'b0 || crd !== 1'b0 ||
                (s > 0 && {caddr_wr, cdata_wr, caddr_rd, csel} !== {m_awr, m_dwr, m_ard, m_csel})) begin
                n_fail++;
                $display("FAIL bus_idle[%0d]: got cwr=%b crd=%b awr=%h ard=%h csel=%0d, required strobes 0 awr=%h ard=%h csel=%0d",
                         s, cwr, crd, caddr_wr, caddr_rd, csel, m_awr, m_ard, m_csel);
            end
            lat = $urandom_range(1, 10);
            for (int c = 0; c <= lat; c++) begin
                rand_eng();
                if (c == 0)        stg_done = stage_mask(s) | 6'($urandom);
                else if (c == lat) stg_done = stage_mask(s) | 6'($urandom);
                else               stg_done = 6'($urandom) & ~stage_mask(s);
                m_cwr  = eng_cwr[s];
                m_crd  = eng_crd[s] & ~eng_cwr[s];
                m_awr  = eng_caddr_wr[s*AW +: AW];
                m_dwr  = eng_cdata_wr[s*DW +: DW];
                m_ard  = eng_caddr_rd[s*AW +: AW];
                m_csel = eng_cwr[s] ? wr_tbl[s] : rd_tbl[s];
                @(negedge clk);
                stg_done = '0;
                n_checks++;
                if ({cwr, crd, caddr_wr, cdata_wr, caddr_rd, csel} !== {m_cwr, m_crd, m_awr, m_dwr, m_ard, m_csel}) begin
                    n_fail++;
                    $display("FAIL bus_mux[%0d.%0d]: got cwr=%b crd=%b awr=%h dwr=%h ard=%h csel=%0d, required cwr=%b crd=%b awr=%h dwr=%h ard=%h csel=%0d",
                             s, c, cwr, crd, caddr_wr, cdata_wr, caddr_rd, csel,
                             m_cwr, m_crd, m_awr, m_dwr, m_ard, m_csel);
                end
                if (c < lat) begin
                    n_checks++;
                    if (stg_idx !== 3'(s) || busy !== 1'b1 || stg_start !== '0) begin
                        n_fail++;
                        $display("FAIL stage_hold[%0d.%0d]: got idx=%0d busy=%b start=%b, required idx=%0d busy=1 start=000000",
                                 s, c, stg_idx, busy, stg_start, s);
                    end
                end
            end
            n_checks++;
            if (s < NS - 1) begin
                if (stg_idx !== 3'(s + 1) || busy !== 1'b1 || stg_start !== '0) begin
                    n_fail++;
                    $display("FAIL gap[%0d]: got idx=%0d busy=%b start=%b, required idx=%0d busy=1 start=000000",
                             s, stg_idx, busy, stg_start, s + 1);
                end
                rand_eng();
                @(negedge clk);
            end else begin
                if (busy !== 1'b0 || stg_start !== '0) begin
                    n_fail++;
                    $display("FAIL run_end: got busy=%b start=%b, required 0/000000", busy, stg_start);
                end
            end
        end
        rand_eng();
        @(negedge clk);
        n_checks++;
        if ({busy, cwr, crd, caddr_wr, cdata_wr, caddr_rd, csel} !== {1'b0, 1'b0, 1'b0, m_awr, m_dwr, m_ard, m_csel}) begin
            n_fail++;
            $display("FAIL idle_hold: got busy=%b cwr=%b crd=%b awr=%h ard=%h csel=%0d, required busy=0 strobes 0 awr=%h ard=%h csel=%0d",
                     busy, cwr, crd, caddr_wr, caddr_rd, csel, m_awr, m_ard, m_csel);
        end
        clear_eng();
    endtask

    task automatic test_ignore_other_done();
        start_run();
        advance(0);
        advance(1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            stg_done = 6'b111011;
            @(negedge clk);
            n_checks++;
            if (stg_idx !== 3'd2 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL foreign_done[%0d]: got idx=%0d busy=%b, required idx=2 busy=1", k, stg_idx, busy);
            end
        end
        stg_done = 6'b000100;
        @(negedge clk);
        stg_done = '0;
        n_checks++;
        if (stg_idx !== 3'd3 || stg_start !== '0) begin
            n_fail++;
            $display("FAIL own_done: got idx=%0d start=%b, required idx=3 start=000000", stg_idx, stg_start);
        end
        @(negedge clk);
        n_checks++;
        if (stg_start !== 6'b001000) begin
            n_fail++;
            $display("FAIL start_after_gap: got %b, required 001000", stg_start);
        end
        advance(3);
        advance(4);
        advance(5);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_run_end: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_write_priority();
        start_run();
        for (int s = 0; s < 4; s++) advance(s);
        rand_eng();
        eng_cwr[4] = 1'b1;
        eng_crd[4] = 1'b1;
        eng_caddr_wr[4*AW +: AW] = 12'h0A5;
        eng_caddr_rd[4*AW +: AW] = 12'h3FF;
        @(negedge clk);
        n_checks++;
        if ({cwr, crd, caddr_wr, caddr_rd, csel} !== {1'b1, 1'b0, 12'h0A5, 12'h3FF, 3'd5}) begin
            n_fail++;
            $display("FAIL write_priority: got cwr=%b crd=%b awr=%h ard=%h csel=%0d, required 1/0/0a5/3ff/5",
                     cwr, crd, caddr_wr, caddr_rd, csel);
        end
        eng_cwr[4] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cwr, crd, csel} !== {1'b0, 1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL read_bank_s4: got cwr=%b crd=%b csel=%0d, required 0/1/3", cwr, crd, csel);
        end
        stg_done = stage_mask(4);
        @(negedge clk);
        stg_done = '0;
        @(negedge clk);
        clear_eng();
        eng_crd = stage_mask(5);
        @(negedge clk);
        n_checks++;
        if ({cwr, crd, csel} !== {1'b0, 1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL read_bank_s5: got cwr=%b crd=%b csel=%0d, required 0/1/4", cwr, crd, csel);
        end
        eng_cwr = stage_mask(5);
        stg_done = stage_mask(5);
        @(negedge clk);
        stg_done = '0;
        n_checks++;
        if ({busy, cwr, crd, csel} !== {1'b0, 1'b1, 1'b0, 3'd5}) begin
            n_fail++;
            $display("FAIL write_bank_s5: got busy=%b cwr=%b crd=%b csel=%0d, required 0/1/0/5", busy, cwr, crd, csel);
        end
        clear_eng();
    endtask

    task automatic test_reset_midrun();
        start_run();
        for (int s = 0; s < 3; s++) advance(s);
        clear_eng();
        eng_cwr = stage_mask(3);
        eng_caddr_wr[3*AW +: AW] = 12'h123;
        eng_cdata_wr[3*DW +: DW] = 20'h5A5A5;
        @(negedge clk);
        n_checks++;
        if ({cwr, caddr_wr, cdata_wr, csel} !== {1'b1, 12'h123, 20'h5A5A5, 3'd4}) begin
            n_fail++;
            $display("FAIL pre_reset_write: got cwr=%b awr=%h dwr=%h csel=%0d, required 1/123/5a5a5/4", cwr, caddr_wr, cdata_wr, csel);
        end
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, stg_start, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, stg_idx, err} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b cwr=%b awr=%h csel=%0d idx=%0d, required all zero",
                     busy, cwr, caddr_wr, csel, stg_idx);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_eng();
        start_run();
        n_checks++;
        if (stg_start !== 6'b000001 || stg_idx !== 3'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_after_reset: got start=%b idx=%0d busy=%b, required 000001/0/1", stg_start, stg_idx, busy);
        end
        for (int s = 0; s < NS; s++) advance(s);
    endtask

    task automatic test_ready_held();
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        for (int s = 0; s < NS; s++) begin
            n_checks++;
            if (stg_start !== stage_mask(s)) begin
                n_fail++;
                $display("FAIL held_start[%0d]: got %b, required %b", s, stg_start, stage_mask(s));
            end
            advance(s);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_return_idle: got busy=%b, required 0", busy);
        end
        @(negedge clk);
        n_checks++;
        if (stg_start !== 6'b000001 || busy !== 1'b1 || stg_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL held_second_run: got start=%b busy=%b idx=%0d, required 000001/1/0", stg_start, busy, stg_idx);
        end
        ready = 1'b0;
        for (int s = 0; s < NS; s++) advance(s);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || stg_start !== '0) begin
                n_fail++;
                $display("FAIL stays_idle[%0d]: got busy=%b start=%b, required 0/000000", k, busy, stg_start);
            end
        end
    endtask

`ifdef STAGE_WATCHDOG_EN
    task automatic test_watchdog();
        start_run();
        advance(0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            n_checks++;
            if (k < 15) begin
                if (err !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wd_early[%0d]: got err=%b busy=%b, required 0/1", k, err, busy);
                end
            end else begin
                if (err !== 1'b1 || busy !== 1'b0 || stg_start !== '0 || cwr !== 1'b0 || crd !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wd_fire: got err=%b busy=%b start=%b, required 1/0/000000", err, busy, stg_start);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_sticky: got err=%b busy=%b, required 1/0", err, busy);
        end
        start_run();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1 || stg_start !== 6'b000001) begin
            n_fail++;
            $display("FAIL wd_clear: got err=%b busy=%b start=%b, required 0/1/000001", err, busy, stg_start);
        end
        for (int s = 0; s < NS; s++) advance(s);
    endtask
`endif

    initial begin
        reset = 1'b1;
        ready = 1'b0;
        stg_done = '0;
        clear_eng();
        test_reset();
        test_full_run();
        test_full_run();
        test_ignore_other_done();
        test_write_priority();
        test_reset_midrun();
        test_ready_held();
`ifdef STAGE_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at time %0t, required completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
